// File: rtl/scalar_rf_pkg.sv
// rtl/scalar_rf_pkg.sv - shared FSM encoding and parameter defaults for the operand fetch unit
//
// Purpose : state encoding for the operand fetch FSM and the default
//           data width, address width and register count.
// Ports   : none (package).

package scalar_rf_pkg;

  localparam int DEF_BIT_NUMBER      = 32;
  localparam int DEF_ADDR_NUMBER     = 5;
  localparam int DEF_REGISTER_NUMBER = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - scalar register file operand fetch / writeback sequencer
//
// Purpose : arbitrates writebacks and operand-fetch requests onto a single
//           synchronous-read register file and delivers both source operands
//           through a valid/ready handshake.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           req_*                  - operand-fetch request (valid/ready, src_1, src_2, dest)
//           wb_*                   - writeback request (valid/ready, addr, data)
//           rf_*                   - register-file strobes, addresses and data
//           op_*                   - operand delivery (valid/ready, a, b, dest, err)
//           wb_err                 - one-cycle pulse for a writeback to an unimplemented register

module operand_fetch_unit
  import scalar_rf_pkg::*;
#(
  parameter int BIT_NUMBER      = DEF_BIT_NUMBER,
  parameter int ADDR_NUMBER     = DEF_ADDR_NUMBER,
  parameter int REGISTER_NUMBER = DEF_REGISTER_NUMBER
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_NUMBER-1:0] req_src_1,
  input  logic [ADDR_NUMBER-1:0] req_src_2,
  input  logic [ADDR_NUMBER-1:0] req_dest,

  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [ADDR_NUMBER-1:0] wb_addr,
  input  logic [BIT_NUMBER-1:0]  wb_data,

  output logic                   rf_enable,
  output logic                   rf_write_enable,
  output logic [ADDR_NUMBER-1:0] rf_src_addr_1,
  output logic [ADDR_NUMBER-1:0] rf_src_addr_2,
  output logic [ADDR_NUMBER-1:0] rf_dest_addr,
  output logic [BIT_NUMBER-1:0]  rf_write_data,
  input  logic [BIT_NUMBER-1:0]  rf_data_out_1,
  input  logic [BIT_NUMBER-1:0]  rf_data_out_2,

  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [BIT_NUMBER-1:0]  op_a,
  output logic [BIT_NUMBER-1:0]  op_b,
  output logic [ADDR_NUMBER-1:0] op_dest,
  output logic                   op_err,
  output logic                   wb_err
);

  // One extra bit so a register count equal to 2**ADDR_NUMBER still compares correctly.
  localparam logic [ADDR_NUMBER:0] REG_LIMIT = (ADDR_NUMBER + 1)'(REGISTER_NUMBER);

  function automatic logic addr_ok(input logic [ADDR_NUMBER-1:0] addr);
    return ({1'b0, addr} < REG_LIMIT);
  endfunction

  fsm_state_t state_q, state_d;

  logic [ADDR_NUMBER-1:0] src_1_q, src_2_q, dest_q;
  logic [ADDR_NUMBER-1:0] wb_addr_q;
  logic [BIT_NUMBER-1:0]  wb_data_q;

  logic [BIT_NUMBER-1:0]  op_a_q, op_b_q;
  logic [ADDR_NUMBER-1:0] op_dest_q;
  logic                   op_err_q;
  logic                   wb_err_q;

  logic in_idle;
  logic wb_fire;
  logic req_fire;
  logic src_1_ok;
  logic src_2_ok;

  // Handshakes are decoded outside the FSM block so the next-state logic
  // never depends on outputs it produces itself.
  assign in_idle   = (state_q == ST_IDLE);
  assign wb_ready  = in_idle && !reset;
  assign req_ready = in_idle && !reset && !wb_valid;
  assign wb_fire   = wb_valid && wb_ready;
  assign req_fire  = req_valid && req_ready;

  assign src_1_ok  = addr_ok(src_1_q);
  assign src_2_ok  = addr_ok(src_2_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rf_enable       = 1'b0;
    rf_write_enable = 1'b0;
    rf_src_addr_1   = '0;
    rf_src_addr_2   = '0;
    rf_dest_addr    = '0;
    rf_write_data   = '0;
    op_valid        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wb_fire) begin
          // Out-of-range writebacks are swallowed here; only wb_err reports them.
          state_d = addr_ok(wb_addr) ? ST_WRITE : ST_IDLE;
        end else if (req_fire) begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        rf_enable       = 1'b1;
        rf_write_enable = 1'b1;
        rf_dest_addr    = wb_addr_q;
        rf_write_data   = wb_data_q;
        state_d         = ST_IDLE;
      end
      ST_READ: begin
        rf_enable     = 1'b1;
        rf_src_addr_1 = src_1_q;
        rf_src_addr_2 = src_2_q;
        state_d       = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_1_q   <= '0;
      src_2_q   <= '0;
      dest_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_dest_q <= '0;
      op_err_q  <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      wb_err_q <= 1'b0;

      if (wb_fire) begin
        wb_addr_q <= wb_addr;
        wb_data_q <= wb_data;
        wb_err_q  <= !addr_ok(wb_addr);
      end

      if (req_fire) begin
        src_1_q <= req_src_1;
        src_2_q <= req_src_2;
        dest_q  <= req_dest;
      end

      // The register file answers the READ-cycle addresses one edge later,
      // so its outputs are valid throughout CAPTURE.
      if (state_q == ST_CAPTURE) begin
        op_a_q    <= src_1_ok ? rf_data_out_1 : '0;
        op_b_q    <= src_2_ok ? rf_data_out_2 : '0;
        op_dest_q <= dest_q;
        op_err_q  <= !(src_1_ok && src_2_ok);
      end
    end
  end

  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign op_dest = op_dest_q;
  assign op_err  = op_err_q;
  assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - scoreboard bench for operand_fetch_unit

module tb_operand_fetch_unit;

  localparam int BN = 32;
  localparam int AN = 5;
  localparam int RN = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [AN-1:0] req_src_1, req_src_2, req_dest;
  logic          wb_valid, wb_ready;
  logic [AN-1:0] wb_addr;
  logic [BN-1:0] wb_data;
  logic          rf_enable, rf_write_enable;
  logic [AN-1:0] rf_src_addr_1, rf_src_addr_2, rf_dest_addr;
  logic [BN-1:0] rf_write_data, rf_data_out_1, rf_data_out_2;
  logic          op_valid, op_ready;
  logic [BN-1:0] op_a, op_b;
  logic [AN-1:0] op_dest;
  logic          op_err, wb_err;

  operand_fetch_unit #(.BIT_NUMBER(BN), .ADDR_NUMBER(AN), .REGISTER_NUMBER(RN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_1(req_src_1), .req_src_2(req_src_2), .req_dest(req_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_enable(rf_enable), .rf_write_enable(rf_write_enable),
    .rf_src_addr_1(rf_src_addr_1), .rf_src_addr_2(rf_src_addr_2), .rf_dest_addr(rf_dest_addr),
    .rf_write_data(rf_write_data), .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_dest(op_dest), .op_err(op_err), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BN-1:0] a;
    logic [BN-1:0] b;
    logic [AN-1:0] dest;
    logic          err;
    int            due;
  } exp_op_t;

  typedef struct {
    logic [AN-1:0] addr;
    logic [BN-1:0] data;
    int            due;
  } exp_wr_t;

  exp_op_t       op_q[$];
  exp_wr_t       wr_q[$];
  logic [BN-1:0] rf_mem   [0:RN-1];
  logic [BN-1:0] ref_regs [0:RN-1];

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   rdy_mode = 0;
  logic mem_init;

  function automatic logic [BN-1:0] init_val(input int i);
    return 32'(i) * 32'h0101_0101 + 32'h0000_0011;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired (cycle %0d)", name, cyc);
  endtask

  // Register file: synchronous read, unimplemented addresses read as garbage.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < RN; i++) rf_mem[i] <= init_val(i);
      rf_data_out_1 <= '0;
      rf_data_out_2 <= '0;
    end else if (rf_enable) begin
      if (rf_write_enable) begin
        if (int'(rf_dest_addr) < RN) rf_mem[rf_dest_addr[3:0]] <= rf_write_data;
      end else begin
        rf_data_out_1 <= (int'(rf_src_addr_1) < RN) ? rf_mem[rf_src_addr_1[3:0]] : 32'hDEAD_BEEF;
        rf_data_out_2 <= (int'(rf_src_addr_2) < RN) ? rf_mem[rf_src_addr_2[3:0]] : 32'hDEAD_BEEF;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // op_ready: 0 = always ready, 1 = random, 2 = stall each delivery five cycles.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    op_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: op_ready = 1'b1;
        1: op_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (op_valid) begin
            hold_cnt++;
            op_ready = (hold_cnt > 5);
          end else begin
            hold_cnt = 0;
            op_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic          rst_prev, prev_valid, prev_ready, prev_err;
    logic [BN-1:0] prev_a, prev_b;
    logic [AN-1:0] prev_dest;
    int            bad_due;
    exp_op_t       eo;
    exp_wr_t       ew;
    rst_prev = 1'b1; prev_valid = 1'b0; prev_ready = 1'b0; prev_err = 1'b0;
    prev_a = '0; prev_b = '0; prev_dest = '0; bad_due = -1;
    forever begin
      @(negedge clk);
      if (mem_init) for (int i = 0; i < RN; i++) ref_regs[i] = init_val(i);

      if (reset) check("reset_ready", {62'd0, req_ready, wb_ready}, 64'd0);
      if (reset && rst_prev) begin
        check("reset_ctrl", {59'd0, op_valid, op_err, wb_err, rf_enable, rf_write_enable}, 64'd0);
        check("reset_op_ab", {op_a, op_b}, 64'd0);
        check("reset_addr", {44'd0, op_dest, rf_src_addr_1, rf_src_addr_2, rf_dest_addr}, 64'd0);
        check("reset_wdata", {32'd0, rf_write_data}, 64'd0);
      end

      if (!rst_prev) begin
        if (rf_write_enable) begin
          if (wr_q.size() == 0) fail_now("unexpected_write");
          else begin
            ew = wr_q.pop_front();
            check("write_cmd", {26'd0, rf_enable, rf_dest_addr, rf_write_data}, {26'd0, 1'b1, ew.addr, ew.data});
            check("write_cycle", 64'(cyc), 64'(ew.due));
          end
        end
        if (wb_err || cyc == bad_due) check("wb_err", {63'd0, wb_err}, {63'd0, cyc == bad_due});
        if (req_ready) check("wb_priority", {62'd0, wb_valid, wb_ready}, 64'd1);
        if (op_valid) check("hold_readies", {62'd0, req_ready, wb_ready}, 64'd0);
        if (op_valid && !prev_valid) begin
          if (op_q.size() == 0) fail_now("unexpected_delivery");
          else check("latency", 64'(cyc), 64'(op_q[0].due));
        end
        if (prev_valid && !prev_ready) begin
          check("hold_stable", {25'd0, op_valid, op_err, op_dest, op_a}, {25'd0, 1'b1, prev_err, prev_dest, prev_a});
          check("hold_stable_b", {32'd0, op_b}, {32'd0, prev_b});
        end
        if (prev_valid && prev_ready && !reset) check("idle_after", {62'd0, op_valid, wb_ready}, 64'd1);
        if (op_valid && op_ready && op_q.size() != 0) begin
          eo = op_q.pop_front();
          check("op_a_dest_err", {26'd0, op_err, op_dest, op_a}, {26'd0, eo.err, eo.dest, eo.a});
          check("op_b", {32'd0, op_b}, {32'd0, eo.b});
        end
      end

      if (!reset) begin
        if (wb_valid && wb_ready) begin
          if (int'(wb_addr) < RN) begin
            ew.addr = wb_addr; ew.data = wb_data; ew.due = cyc + 1;
            wr_q.push_back(ew);
            ref_regs[wb_addr[3:0]] = wb_data;
          end else begin
            bad_due = cyc + 1;
          end
        end
        if (req_valid && req_ready) begin
          eo.a    = (int'(req_src_1) < RN) ? ref_regs[req_src_1[3:0]] : '0;
          eo.b    = (int'(req_src_2) < RN) ? ref_regs[req_src_2[3:0]] : '0;
          eo.err  = (int'(req_src_1) >= RN) || (int'(req_src_2) >= RN);
          eo.dest = req_dest;
          eo.due  = cyc + 3;
          op_q.push_back(eo);
        end
      end

      prev_valid = op_valid; prev_ready = op_ready; prev_err = op_err;
      prev_a = op_a; prev_b = op_b; prev_dest = op_dest;
      rst_prev = reset;
      if (reset) begin
        op_q.delete();
        wr_q.delete();
        bad_due = -1;
        prev_valid = 1'b0;
      end
    end
  end

  task automatic xfer(input bit wv, input logic [AN-1:0] wa, input logic [BN-1:0] wd,
                      input bit rv, input logic [AN-1:0] s1, input logic [AN-1:0] s2,
                      input logic [AN-1:0] d);
    int  guard;
    bit  wdone, rdone;
    wb_valid = wv;  wb_addr = wa;  wb_data = wd;
    req_valid = rv; req_src_1 = s1; req_src_2 = s2; req_dest = d;
    guard = 0;
    while ((wb_valid || req_valid) && guard < 100) begin
      @(negedge clk);
      wdone = wb_valid && wb_ready;
      rdone = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (wdone) wb_valid = 1'b0;
      if (rdone) req_valid = 1'b0;
      guard++;
    end
    if (wb_valid || req_valid) begin
      fail_now("xfer_timeout");
      wb_valid = 1'b0;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((op_q.size() != 0 || wr_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (op_q.size() != 0 || wr_q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AN-1:0] a1, a2, a3;
    int            sel;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_src_1 = '0; req_src_2 = '0; req_dest = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    reset = 1'b0;

    // Write then read of the same register.
    xfer(1'b1, 5'd3, 32'h0000_00A5, 1'b0, '0, '0, '0);
    xfer(1'b0, '0, '0, 1'b1, 5'd3, 5'd0, 5'd9);
    drain();

    // Simultaneous writeback and request: writeback must win.
    xfer(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd2, 5'd4);
    drain();

    // Unimplemented source register.
    xfer(1'b0, '0, '0, 1'b1, 5'd5, 5'd20, 5'd1);
    drain();

    // Writeback to unimplemented register.
    xfer(1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, '0, '0, '0);
    check("bad_wb_idle", {62'd0, wb_ready, rf_write_enable}, 64'd2);
    drain();

    // Five-cycle stall in HOLD.
    rdy_mode = 2;
    xfer(1'b0, '0, '0, 1'b1, 5'd7, 5'd3, 5'd12);
    drain();
    rdy_mode = 0;

    // Reset while READ is in progress.
    xfer(1'b0, '0, '0, 1'b1, 5'd1, 5'd2, 5'd3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Random mix.
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      a1 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      a2 = 5'($urandom_range(0, 20));
      a3 = 5'($urandom_range(0, 20));
      if (sel < 3)      xfer(1'b1, a1, $urandom, 1'b0, '0, '0, '0);
      else if (sel < 8) xfer(1'b0, '0, '0, 1'b1, a2, a3, 5'($urandom_range(0, 31)));
      else              xfer(1'b1, a1, $urandom, 1'b1, a2, a3, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, the data word width.
REQ-002 SHALL have parameter ADDR_NUMBER, default 5, the register address width.
REQ-003 SHALL have parameter REGISTER_NUMBER, default 16, the count of implemented registers.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid/req_ready  input/output  1/1  operand-fetch request handshake.
REQ-007 SHALL have ports req_src_1, req_src_2, req_dest  input  ADDR_NUMBER each  request addresses.
REQ-008 SHALL have ports wb_valid/wb_ready  input/output  1/1  writeback request handshake.
REQ-009 SHALL have ports wb_addr  input  ADDR_NUMBER, and wb_data  input  BIT_NUMBER  writeback target and value.
REQ-010 SHALL have ports rf_enable, rf_write_enable  output  1 each  register-file strobes.
REQ-011 SHALL have ports rf_src_addr_1, rf_src_addr_2, rf_dest_addr  output  ADDR_NUMBER each  register-file addresses.
REQ-012 SHALL have ports rf_write_data  output  BIT_NUMBER, and rf_data_out_1, rf_data_out_2  input  BIT_NUMBER  register-file data.
REQ-013 SHALL have ports op_valid/op_ready  output/input  1/1  operand-delivery handshake.
REQ-014 SHALL have ports op_a, op_b  output  BIT_NUMBER; op_dest  output  ADDR_NUMBER; op_err, wb_err  output  1 each.

Function
REQ-015 SHALL implement the FSM states IDLE, WRITE, READ, CAPTURE and HOLD.
REQ-016 SHALL drive wb_ready=1 only in IDLE, and req_ready=1 only in IDLE with wb_valid=0, giving writeback strict priority.
REQ-017 SHALL, on wb_valid&&wb_ready, latch wb_addr/wb_data and enter WRITE.
REQ-018 SHALL, in WRITE, drive rf_enable=1, rf_write_enable=1, rf_dest_addr/rf_write_data from the latch for exactly one cycle, then return to IDLE.
REQ-019 SHALL, on req_valid&&req_ready, latch the three request addresses and enter READ.
REQ-020 SHALL, in READ, drive rf_enable=1, rf_write_enable=0 and rf_src_addr_1/2 from the latch, then enter CAPTURE.
REQ-021 SHALL, in CAPTURE, drive rf_enable=0, register rf_data_out_1/2 into op_a/op_b and the latched dest into op_dest, then enter HOLD.
REQ-022 SHALL hold op_valid=1, with op_a/op_b/op_dest/op_err stable, throughout HOLD.
REQ-023 SHALL leave HOLD for IDLE on op_valid&&op_ready, deasserting op_valid at that edge.
REQ-024 SHALL have a latency in which a request accepted at edge k raises op_valid from edge k+2; minimum request-to-request spacing is 3 cycles plus HOLD stall.
REQ-025 SHALL drive rf_enable=0 and rf_write_enable=0 in IDLE, CAPTURE and HOLD; rf_write_enable=1 SHALL never coincide with READ.
REQ-026 SHALL treat a source address >= REGISTER_NUMBER by forcing the matching op_a/op_b to 0 and setting op_err=1 for that delivery; READ SHALL still be issued.
REQ-027 SHALL accept a writeback with wb_addr >= REGISTER_NUMBER but issue no WRITE, return directly to IDLE, and pulse wb_err=1 for one cycle.
REQ-028 SHALL give simultaneous wb_valid and req_valid in IDLE the following order: the writeback completes first and the request is accepted on a later IDLE cycle, so a read after a write to the same register returns the new value.

Reset
REQ-029 SHALL, when reset=1 at a rising edge, enter IDLE and clear op_valid, op_a, op_b, op_dest, op_err, wb_err, rf_enable, rf_write_enable, all rf address/data outputs and all latches to 0.
REQ-030 SHALL, on reset asserted mid-operation in any state, abandon the in-flight transaction with no write or delivery after that edge.
REQ-031 SHALL hold req_ready=0 and wb_ready=0 while reset=1.

Structure
REQ-032 SHALL place the state encoding constants and the parameter defaults (32/5/16) in shared package scalar_rf_pkg.
REQ-033 SHALL be a single module with no sub-module.

Verification
REQ-034 SHALL cover the scenario: after reset, wb of 0x0000_00A5 to reg 3, then request src_1=3, src_2=0 -> WRITE one cycle with rf_dest_addr=3, then op_a=0x0000_00A5 and op_valid at accept+2.
REQ-035 SHALL cover the scenario: wb_valid and req_valid raised together, wb reg 7=0x1234_5678, request src_1=7 -> write issued first, op_a=0x1234_5678.
REQ-036 SHALL cover the scenario: request src_2=20 -> op_b=0, op_err=1, op_a correct.
REQ-037 SHALL cover the scenario: wb_addr=31 -> no rf_write_enable pulse, wb_err=1 for one cycle, FSM back in IDLE next cycle.
REQ-038 SHALL cover the scenario: op_ready held 0 for 5 cycles in HOLD -> op_valid and data stable, req_ready=0 and wb_ready=0 throughout, IDLE after op_ready=1.
REQ-039 SHALL cover the scenario: reset asserted in READ -> next cycle all outputs 0 and no op_valid or write ever issued for the aborted request.
